// File: rtl/lfsr_keystream.sv
// -----------------------------------------------------------------------------
// lfsr_keystream
//   Galois LFSR keystream generator. A host loads a non-zero seed, then asks
//   for a burst of num_words key words. Each word is offered on key/key_valid
//   and advances only when the downstream XOR stage accepts it (key_ready).
//   The LFSR is never re-seeded on its own, so consecutive bursts continue
//   one unbroken sequence.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        synchronous active-high reset
//   seed_load  in   1        strobe: load seed (IDLE only, seed must be != 0)
//   seed       in   N        seed value
//   start      in   1        strobe: begin a burst (IDLE only)
//   num_words  in   COUNT_W  burst length, sampled with start
//   key        out  N        current LFSR state (drives xoroperator.b)
//   key_valid  out  1        key is offered to the consumer
//   key_ready  in   1        consumer accepts key this cycle
//   busy       out  1        burst in progress
//   done       out  1        one-cycle pulse after the final word is taken
//   seed_err   out  1        one-cycle pulse when a seed load is rejected
// -----------------------------------------------------------------------------
module lfsr_keystream #(
  parameter int           N       = 8,
  parameter logic [N-1:0] TAPS    = 8'hB8,
  parameter int           COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_load,
  input  logic [N-1:0]       seed,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_words,
  output logic [N-1:0]       key,
  output logic               key_valid,
  input  logic               key_ready,
  output logic               busy,
  output logic               done,
  output logic               seed_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [N-1:0]       lfsr;
  logic [COUNT_W-1:0] count;

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
    return {1'b0, s[N-1:1]} ^ (s[0] ? TAPS : {N{1'b0}});
  endfunction

  // The key is the LFSR register itself, so it is registered in every state.
  assign key = lfsr;

  // Burst controller, LFSR and all registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= {N{1'b1}};
      count     <= {COUNT_W{1'b0}};
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      seed_err  <= 1'b0;
    end else begin
      // done and seed_err are pulses; they only rise for one cycle.
      done     <= 1'b0;
      seed_err <= 1'b0;
      case (state)
        IDLE: begin
          // Seed is applied at the same edge as start, so a simultaneous
          // load makes the new seed the first key of the burst.
          if (seed_load) begin
            if (seed != {N{1'b0}}) begin
              lfsr <= seed;
            end else begin
              seed_err <= 1'b1;
            end
          end
          if (start) begin
            if (num_words != {COUNT_W{1'b0}}) begin
              count     <= num_words;
              state     <= RUN;
              key_valid <= 1'b1;
              busy      <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (seed_load) begin
            seed_err <= 1'b1;
          end
          if (key_valid && key_ready) begin
            lfsr  <= lfsr_step(lfsr);
            count <= count - {{(COUNT_W-1){1'b0}}, 1'b1};
            // Leaving from count == 1 means the counter never wraps.
            if (count == {{(COUNT_W-1){1'b0}}, 1'b1}) begin
              state     <= DONE;
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        DONE: begin
          if (seed_load) begin
            seed_err <= 1'b1;
          end
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          key_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_keystream.sv
// -----------------------------------------------------------------------------
// tb_lfsr_keystream
//   Self-checking bench for lfsr_keystream: a directed vector table, a
//   hand-written reset/continuity sequence, and a randomized run checked
//   against a burst-level reference model.
// -----------------------------------------------------------------------------
module tb_lfsr_keystream;

  localparam int N = 8;
  localparam int CW = 8;
  localparam logic [7:0] TAPS_C = 8'hB8;

  logic          clk;
  logic          rst;
  logic          seed_load;
  logic [N-1:0]  seed;
  logic          start;
  logic [CW-1:0] num_words;
  logic [N-1:0]  key;
  logic          key_valid;
  logic          key_ready;
  logic          busy;
  logic          done;
  logic          seed_err;

  int errors = 0;
  int checks = 0;

  lfsr_keystream #(.N(N), .TAPS(TAPS_C), .COUNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .seed      (seed),
    .start     (start),
    .num_words (num_words),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .busy      (busy),
    .done      (done),
    .seed_err  (seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       sl;
    logic [7:0] sd;
    logic       st;
    logic [7:0] nw;
    logic       rdy;
    logic [7:0] k;
    logic       v;
    logic       b;
    logic       d;
    logic       e;
  } vec_t;

  vec_t tbl[33];

  // Reference next-word rule written with plain arithmetic.
  function automatic logic [7:0] ref_step(input logic [7:0] s);
    int unsigned x;
    x = int'(s);
    if ((x % 2) == 1) return 8'((x / 2) ^ int'(TAPS_C));
    else              return 8'(x / 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] k, input logic v,
                         input logic b, input logic d, input logic e);
    chk({tag, ".key"},       32'(key),       32'(k));
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(v));
    chk({tag, ".busy"},      32'(busy),      32'(b));
    chk({tag, ".done"},      32'(done),      32'(d));
    chk({tag, ".seed_err"},  32'(seed_err),  32'(e));
  endtask

  task automatic drive(input logic sl, input logic [7:0] sd, input logic st,
                       input logic [7:0] nw, input logic rdy);
    seed_load = sl;
    seed      = sd;
    start     = st;
    num_words = nw;
    key_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random-phase model state: words still owed, pending done pulse, LFSR.
  logic [7:0] m_lfsr;
  int         m_left;
  logic       m_done;
  logic       m_err;

  initial begin
    // sl  seed   st nw     rdy   key    v b d e
    tbl[0]  = '{1'b1, 8'h01, 1'b0, 8'd0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 8'd5, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'hB8, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'h5C, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'h2E, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'h17, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 8'd0, 1'b0, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 8'd0, 1'b0, 8'hB3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 8'h01, 1'b0, 8'd0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 8'd5, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'hB8, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'hB8, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'hB8, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'hB8, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'h5C, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'h2E, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[20] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'h17, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[22] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[23] = '{1'b1, 8'h01, 1'b1, 8'd3, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[24] = '{1'b1, 8'h55, 1'b0, 8'd0, 1'b1, 8'hB8, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[25] = '{1'b0, 8'h00, 1'b1, 8'd9, 1'b1, 8'h5C, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'h2E, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[27] = '{1'b1, 8'h33, 1'b0, 8'd0, 1'b0, 8'h2E, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[28] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'h2E, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[29] = '{1'b0, 8'h00, 1'b1, 8'd1, 1'b0, 8'h2E, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[30] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'h2E, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[31] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 8'h17, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[32] = '{1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 8'h17, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset defaults: two cycles of reset.
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tick();
    tick();
    chk_all("reset", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed table: basic sequence, illegal seeds, zero burst, stalls,
    // ignored start/seed in RUN and DONE.
    for (int i = 0; i < 33; i++) begin
      drive(tbl[i].sl, tbl[i].sd, tbl[i].st, tbl[i].nw, tbl[i].rdy);
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].k, tbl[i].v, tbl[i].b, tbl[i].d, tbl[i].e);
    end

    // Mid-burst reset: two words taken, then reset abandons the burst.
    drive(1'b0, 8'h00, 1'b1, 8'd5, 1'b1);
    tick();
    chk_all("mid.w0", 8'h17, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
    tick();
    chk_all("mid.w1", 8'hB3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("mid.w2", 8'hE1, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    chk_all("mid.rst", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("mid.quiet%0d", i), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Continuity after reset: burst of two from the all-ones state.
    drive(1'b0, 8'h00, 1'b1, 8'd2, 1'b1);
    tick();
    chk_all("cont.w0", 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 8'd0, 1'b1);
    tick();
    chk_all("cont.w1", ref_step(8'hFF), 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk_all("cont.end", ref_step(ref_step(8'hFF)), 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    tick();
    chk_all("cont.idle", ref_step(ref_step(8'hFF)), 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized run against the burst-level model.
    m_lfsr = ref_step(ref_step(8'hFF));
    m_left = 0;
    m_done = 1'b0;
    m_err  = 1'b0;
    for (int c = 0; c < 500; c++) begin
      logic       r_rst, r_sl, r_st, r_rdy, was_pending;
      logic [7:0] r_sd, r_nw;
      r_rst = ($urandom_range(0, 99) == 0);
      r_sl  = ($urandom_range(0, 5) == 0);
      r_sd  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      r_st  = ($urandom_range(0, 3) == 0);
      r_nw  = 8'($urandom_range(0, 6));
      r_rdy = ($urandom_range(0, 2) != 0);
      rst = r_rst;
      drive(r_sl, r_sd, r_st, r_nw, r_rdy);
      tick();
      if (r_rst) begin
        m_lfsr = 8'hFF;
        m_left = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
      end else begin
        was_pending = m_done;
        m_done = 1'b0;
        m_err  = r_sl && ((m_left > 0) || was_pending || (r_sd == 8'h00));
        if (m_left > 0) begin
          if (r_rdy) begin
            m_lfsr = ref_step(m_lfsr);
            m_left = m_left - 1;
            m_done = (m_left == 0);
          end
        end else if (!was_pending) begin
          if (r_sl && r_sd != 8'h00) m_lfsr = r_sd;
          if (r_st) begin
            if (r_nw == 8'd0) m_done = 1'b1;
            else              m_left = int'(r_nw);
          end
        end
      end
      chk_all($sformatf("rnd%0d", c), m_lfsr, (m_left > 0), (m_left > 0), m_done, m_err);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
